// File: rtl/safecrack_lock_ctrl.sv
// Keypad lock controller: code entry with sticky mismatch, failure counting with timed
// lockout, idle discard of partial entries, and in-place reprogramming while open.
module safecrack_lock_ctrl #(
    parameter int unsigned CODE_LEN  = 3,
    parameter int unsigned BTN_W     = 4,
    parameter int unsigned MAX_ERR   = 3,
    parameter int unsigned LOCK_SECS = 10,
    parameter int unsigned IDLE_SECS = 5,
    parameter logic [CODE_LEN*BTN_W-1:0] DEFAULT_CODE = {4'b0111, 4'b1101, 4'b1101}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic [BTN_W-1:0]     btn,
    input  logic                 ms,
    input  logic                 relock,
    output logic                 unlocked,
    output logic                 prog,
    output logic                 locked_out,
    output logic [MAX_ERR-1:0]   leds_erros,
    output logic [LOCK_SECS-1:0] leds_segundos
);

    localparam int unsigned IDX_W  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int unsigned ERR_W  = $clog2(MAX_ERR + 1);
    localparam int unsigned SEC_W  = $clog2(LOCK_SECS + 1);
    localparam int unsigned IDLE_W = (IDLE_SECS > 0) ? $clog2(IDLE_SECS + 1) : 1;
    localparam bit          IDLE_EN = (IDLE_SECS > 0);

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_OPEN    = 2'd1,
        ST_PROG    = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [BTN_W-1:0]   btn_prev_q;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               mismatch_q, mismatch_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic [SEC_W-1:0]   sec_cnt_q, sec_cnt_d;
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [BTN_W-1:0]   code_q [CODE_LEN];
    logic [BTN_W-1:0]   code_d [CODE_LEN];
    logic [BTN_W-1:0]   shadow_q [CODE_LEN];
    logic [BTN_W-1:0]   shadow_d [CODE_LEN];

    logic                 unlocked_d, prog_d, locked_out_d;
    logic [MAX_ERR-1:0]   leds_erros_d;
    logic [LOCK_SECS-1:0] leds_segundos_d;

    logic               press;
    logic               last_digit;
    logic               digit_bad;
    logic               idle_hit;
    logic [ERR_W-1:0]   err_inc;

    // Next-state, counters and registered-output decode
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mismatch_d = mismatch_q;
        err_cnt_d  = err_cnt_q;
        sec_cnt_d  = sec_cnt_q;
        idle_cnt_d = idle_cnt_q;
        code_d     = code_q;
        shadow_d   = shadow_q;

        press      = (btn != '0) && (btn_prev_q == '0);
        last_digit = (idx_q == IDX_W'(CODE_LEN - 1));
        digit_bad  = (btn != code_q[idx_q]);
        err_inc    = (err_cnt_q == ERR_W'(MAX_ERR)) ? err_cnt_q : err_cnt_q + ERR_W'(1);

        // Idle seconds only accumulate while a partial entry is pending
        if (press || (idx_q == '0) || !IDLE_EN) begin
            idle_cnt_d = '0;
        end else if (tick) begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
        idle_hit = IDLE_EN && (idx_q != '0) && tick && !press &&
                   (idle_cnt_q == IDLE_W'(IDLE_SECS - 1));

        case (state_q)
            ST_ENTRY: begin
                if (press) begin
                    if (last_digit) begin
                        idx_d      = '0;
                        mismatch_d = 1'b0;
                        if (!(mismatch_q || digit_bad)) begin
                            state_d   = ST_OPEN;
                            err_cnt_d = '0;
                        end else begin
                            err_cnt_d = err_inc;
                            if (err_inc == ERR_W'(MAX_ERR)) begin
                                state_d   = ST_LOCKOUT;
                                sec_cnt_d = '0;
                            end
                        end
                    end else begin
                        idx_d      = idx_q + IDX_W'(1);
                        mismatch_d = mismatch_q || digit_bad;
                    end
                end else if (idle_hit) begin
                    idx_d      = '0;
                    mismatch_d = 1'b0;
                end
            end
            ST_OPEN: begin
                idx_d = '0;
                if (relock) begin
                    state_d = ST_ENTRY;
                end else if (ms) begin
                    state_d = ST_PROG;
                end
            end
            ST_PROG: begin
                if (!ms) begin
                    state_d = ST_OPEN;
                    idx_d   = '0;
                end else if (press) begin
                    shadow_d[idx_q] = btn;
                    if (last_digit) begin
                        code_d        = shadow_q;
                        code_d[idx_q] = btn;
                        state_d       = ST_ENTRY;
                        idx_d         = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (idle_hit) begin
                    state_d = ST_OPEN;
                    idx_d   = '0;
                end
            end
            ST_LOCKOUT: begin
                if (tick) begin
                    if (sec_cnt_q == SEC_W'(LOCK_SECS - 1)) begin
                        state_d   = ST_ENTRY;
                        err_cnt_d = '0;
                        sec_cnt_d = '0;
                    end else begin
                        sec_cnt_d = sec_cnt_q + SEC_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_ENTRY;
                idx_d   = '0;
            end
        endcase

        unlocked_d   = (state_d == ST_OPEN);
        prog_d       = (state_d == ST_PROG);
        locked_out_d = (state_d == ST_LOCKOUT);
        for (int unsigned i = 0; i < MAX_ERR; i++) begin
            leds_erros_d[i] = (32'(err_cnt_d) > i);
        end
        for (int unsigned i = 0; i < LOCK_SECS; i++) begin
            leds_segundos_d[i] = (32'(sec_cnt_d) > i);
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_ENTRY;
            btn_prev_q    <= '0;
            idx_q         <= '0;
            mismatch_q    <= 1'b0;
            err_cnt_q     <= '0;
            sec_cnt_q     <= '0;
            idle_cnt_q    <= '0;
            for (int unsigned i = 0; i < CODE_LEN; i++) begin
                code_q[i]   <= DEFAULT_CODE[(CODE_LEN - 1 - i) * BTN_W +: BTN_W];
                shadow_q[i] <= '0;
            end
            unlocked      <= 1'b0;
            prog          <= 1'b0;
            locked_out    <= 1'b0;
            leds_erros    <= '0;
            leds_segundos <= '0;
        end else begin
            state_q       <= state_d;
            btn_prev_q    <= btn;
            idx_q         <= idx_d;
            mismatch_q    <= mismatch_d;
            err_cnt_q     <= err_cnt_d;
            sec_cnt_q     <= sec_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            code_q        <= code_d;
            shadow_q      <= shadow_d;
            unlocked      <= unlocked_d;
            prog          <= prog_d;
            locked_out    <= locked_out_d;
            leds_erros    <= leds_erros_d;
            leds_segundos <= leds_segundos_d;
        end
    end

endmodule

// File: tb/tb_safecrack_lock_ctrl.sv
// Bench for safecrack_lock_ctrl: directed scenarios with literal expectations, then random
// stimulus, all checked every cycle against a queue-based model of the lock rules.
module tb_safecrack_lock_ctrl;

    localparam int CODE_LEN  = 3;
    localparam int BTN_W     = 4;
    localparam int MAX_ERR   = 3;
    localparam int LOCK_SECS = 10;
    localparam int IDLE_SECS = 5;

    localparam int M_ENTRY = 0;
    localparam int M_OPEN  = 1;
    localparam int M_PROG  = 2;
    localparam int M_LOCK  = 3;

    logic                 clk;
    logic                 rst;
    logic                 tick;
    logic [BTN_W-1:0]     btn;
    logic                 ms;
    logic                 relock;
    logic                 unlocked;
    logic                 prog;
    logic                 locked_out;
    logic [MAX_ERR-1:0]   leds_erros;
    logic [LOCK_SECS-1:0] leds_segundos;

    safecrack_lock_ctrl #(
        .CODE_LEN    (CODE_LEN),
        .BTN_W       (BTN_W),
        .MAX_ERR     (MAX_ERR),
        .LOCK_SECS   (LOCK_SECS),
        .IDLE_SECS   (IDLE_SECS),
        .DEFAULT_CODE(12'b0111_1101_1101)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .btn          (btn),
        .ms           (ms),
        .relock       (relock),
        .unlocked     (unlocked),
        .prog         (prog),
        .locked_out   (locked_out),
        .leds_erros   (leds_erros),
        .leds_segundos(leds_segundos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: the code as a list, entered digits as a queue
    int m_mode;
    int m_code [CODE_LEN];
    int m_digits [$];
    int m_err;
    int m_secs;
    int m_idle;
    int m_prev;
    bit ms_lvl;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int thermo(input int n);
        return (1 << n) - 1;
    endfunction

    task automatic model_reset();
        m_mode = M_ENTRY;
        m_digits.delete();
        m_err  = 0;
        m_secs = 0;
        m_idle = 0;
        m_prev = 0;
        m_code[0] = 4'b0111;
        m_code[1] = 4'b1101;
        m_code[2] = 4'b1101;
    endtask

    // One clock of the lock rules, applied to the inputs sampled at this edge
    task automatic model_step();
        int  b;
        bit  pr;
        bit  ok;
        b  = int'(btn);
        pr = (b != 0) && (m_prev == 0);
        m_prev = b;
        case (m_mode)
            M_ENTRY: begin
                if (pr) begin
                    m_digits.push_back(b);
                    m_idle = 0;
                    if (m_digits.size() == CODE_LEN) begin
                        ok = 1'b1;
                        for (int i = 0; i < CODE_LEN; i++)
                            if (m_digits[i] != m_code[i]) ok = 1'b0;
                        m_digits.delete();
                        if (ok) begin
                            m_mode = M_OPEN;
                            m_err  = 0;
                        end else begin
                            m_err++;
                            if (m_err == MAX_ERR) begin
                                m_mode = M_LOCK;
                                m_secs = 0;
                            end
                        end
                    end
                end else if (tick && m_digits.size() > 0) begin
                    m_idle++;
                    if (m_idle == IDLE_SECS) m_digits.delete();
                end
            end
            M_OPEN: begin
                if (relock) m_mode = M_ENTRY;
                else if (ms) begin
                    m_mode = M_PROG;
                    m_digits.delete();
                end
            end
            M_PROG: begin
                if (!ms) begin
                    m_mode = M_OPEN;
                    m_digits.delete();
                end else if (pr) begin
                    m_digits.push_back(b);
                    m_idle = 0;
                    if (m_digits.size() == CODE_LEN) begin
                        for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_digits[i];
                        m_digits.delete();
                        m_mode = M_ENTRY;
                    end
                end else if (tick && m_digits.size() > 0) begin
                    m_idle++;
                    if (m_idle == IDLE_SECS) begin
                        m_digits.delete();
                        m_mode = M_OPEN;
                    end
                end
            end
            default: begin
                if (tick) begin
                    m_secs++;
                    if (m_secs == LOCK_SECS) begin
                        m_mode = M_ENTRY;
                        m_err  = 0;
                        m_secs = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic compare();
        chk("unlocked", int'(unlocked), int'(m_mode == M_OPEN));
        chk("prog", int'(prog), int'(m_mode == M_PROG));
        chk("locked_out", int'(locked_out), int'(m_mode == M_LOCK));
        chk("leds_erros", int'(leds_erros), thermo(m_err));
        chk("leds_segundos", int'(leds_segundos), thermo(m_secs));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            compare();
        end
    end

    task automatic cyc(input logic [BTN_W-1:0] b, input bit t, input bit r);
        btn    = b;
        tick   = t;
        ms     = ms_lvl;
        relock = r;
        @(posedge clk);
        if (rst) model_step();
        #1;
    endtask

    task automatic press(input logic [BTN_W-1:0] d, input int hold);
        repeat (hold) cyc(d, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b0);
    endtask

    task automatic seq3(input logic [BTN_W-1:0] a, input logic [BTN_W-1:0] b,
                        input logic [BTN_W-1:0] c);
        press(a, 2);
        press(b, 2);
        press(c, 2);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_unlocked", int'(unlocked), 0);
        chk("rst_prog", int'(prog), 0);
        chk("rst_locked_out", int'(locked_out), 0);
        chk("rst_leds_erros", int'(leds_erros), 0);
        chk("rst_leds_segundos", int'(leds_segundos), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    logic [BTN_W-1:0] rb;
    bit               rt;
    bit               rr;

    initial begin
        rst    = 1'b0;
        tick   = 1'b0;
        btn    = '0;
        ms     = 1'b0;
        relock = 1'b0;
        ms_lvl = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        cyc('0, 1'b0, 1'b0);

        // Correct default code
        seq3(4'b0111, 4'b1101, 4'b1101);
        chk("open_after_code", int'(unlocked), 1);
        chk("open_errs", int'(leds_erros), 0);
        cyc('0, 1'b0, 1'b1);
        chk("relock", int'(unlocked), 0);

        // One wrong digit, then correct
        seq3(4'b0111, 4'b0001, 4'b1101);
        chk("wrong_locked", int'(unlocked), 0);
        chk("wrong_errs", int'(leds_erros), 3'b001);
        seq3(4'b0111, 4'b1101, 4'b1101);
        chk("retry_open", int'(unlocked), 1);
        chk("retry_errs", int'(leds_erros), 0);
        cyc('0, 1'b0, 1'b1);

        // Lockout and its expiry
        repeat (3) seq3(4'b0001, 4'b0001, 4'b0001);
        chk("lockout", int'(locked_out), 1);
        chk("lockout_errs", int'(leds_erros), 3'b111);
        for (int i = 0; i < 9; i++) begin
            press(4'b0111, 1);
            cyc('0, 1'b1, 1'b0);
        end
        chk("lock_9s", int'(leds_segundos), 10'h1FF);
        chk("lock_still", int'(locked_out), 1);
        cyc(4'b0111, 1'b1, 1'b0);
        chk("lock_end", int'(locked_out), 0);
        chk("lock_end_secs", int'(leds_segundos), 0);
        chk("lock_end_errs", int'(leds_erros), 0);
        cyc(4'b0111, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b0);
        seq3(4'b0111, 4'b1101, 4'b1101);
        chk("post_lock_open", int'(unlocked), 1);

        // Reprogram, old code fails, new code opens, aborted reprogram keeps code
        ms_lvl = 1'b1;
        cyc('0, 1'b0, 1'b0);
        chk("prog_on", int'(prog), 1);
        seq3(4'b0001, 4'b0010, 4'b0100);
        chk("prog_done", int'(prog), 0);
        chk("prog_done_locked", int'(unlocked), 0);
        ms_lvl = 1'b0;
        seq3(4'b0111, 4'b1101, 4'b1101);
        chk("old_code_fails", int'(leds_erros), 3'b001);
        seq3(4'b0001, 4'b0010, 4'b0100);
        chk("new_code_opens", int'(unlocked), 1);
        ms_lvl = 1'b1;
        cyc('0, 1'b0, 1'b0);
        press(4'b0111, 2);
        press(4'b1101, 2);
        ms_lvl = 1'b0;
        cyc('0, 1'b0, 1'b0);
        chk("abort_open", int'(unlocked), 1);
        cyc('0, 1'b0, 1'b1);
        seq3(4'b0001, 4'b0010, 4'b0100);
        chk("abort_kept_code", int'(unlocked), 1);
        cyc('0, 1'b0, 1'b1);

        // Reset mid-lockout
        repeat (3) seq3(4'b0001, 4'b0001, 4'b0001);
        repeat (3) cyc('0, 1'b1, 1'b0);
        chk("lock_3s", int'(leds_segundos), 10'h007);
        do_reset();
        seq3(4'b0111, 4'b1101, 4'b1101);
        chk("default_after_rst", int'(unlocked), 1);

        // Reset mid-PROG
        ms_lvl = 1'b1;
        cyc('0, 1'b0, 1'b0);
        press(4'b0001, 2);
        ms_lvl = 1'b0;
        do_reset();
        seq3(4'b0111, 4'b1101, 4'b1101);
        chk("default_after_prog_rst", int'(unlocked), 1);
        cyc('0, 1'b0, 1'b1);

        // Idle timeout discards the partial entry; a long hold is one press
        press(4'b0111, 5);
        repeat (IDLE_SECS) cyc('0, 1'b1, 1'b0);
        seq3(4'b1101, 4'b1101, 4'b1101);
        chk("idle_no_open", int'(unlocked), 0);
        chk("idle_err", int'(leds_erros), 3'b001);

        // Random traffic, biased toward the current code
        for (int n = 0; n < 5000; n++) begin
            rt = ($urandom_range(0, 9) == 0);
            if (btn != '0)
                rb = ($urandom_range(0, 1) == 1) ? btn : '0;
            else if ($urandom_range(0, 2) == 0)
                rb = ($urandom_range(0, 3) != 0) ? BTN_W'(m_code[m_digits.size() % CODE_LEN])
                                                 : BTN_W'($urandom_range(1, 15));
            else
                rb = '0;
            if ($urandom_range(0, 39) == 0) ms_lvl = ~ms_lvl;
            rr = ($urandom_range(0, 59) == 0);
            cyc(rb, rt, rr);
        end
        cyc('0, 1'b0, 1'b0);
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
